// File: rtl/fp_operand_unpack_if.sv
// rtl/fp_operand_unpack_if.sv - operand-pair stream in, decoded-pair stream out
interface fp_operand_unpack_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   fp_a;
  logic [EXP_W+MAN_W:0]   fp_b;
  logic                   out_valid;
  logic                   out_ready;
  logic                   a_sign;
  logic [EXP_W-1:0]       a_exponent;
  logic [MAN_W:0]         a_significand;
  logic [2:0]             a_class;
  logic                   b_sign;
  logic [EXP_W-1:0]       b_exponent;
  logic [MAN_W:0]         b_significand;
  logic [2:0]             b_class;
  logic                   special_any;

  modport master (
    output in_valid, fp_a, fp_b, out_ready,
    input  in_ready, out_valid,
    input  a_sign, a_exponent, a_significand, a_class,
    input  b_sign, b_exponent, b_significand, b_class,
    input  special_any
  );

  modport slave (
    input  in_valid, fp_a, fp_b, out_ready,
    output in_ready, out_valid,
    output a_sign, a_exponent, a_significand, a_class,
    output b_sign, b_exponent, b_significand, b_class,
    output special_any
  );
endinterface

// File: rtl/fp_operand_unpack.sv
// rtl/fp_operand_unpack.sv - IEEE-754 operand pair decoder, 2-stage elastic pipeline
// Optional FLUSH_DENORM_EN: denormal operands decode as signed zero.
module fp_operand_unpack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                clock,
  input  logic                resetn,
  fp_operand_unpack_if.slave  bus
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int DW = 1 + EXP_W + (MAN_W + 1) + 3;

  localparam logic [2:0] CLS_ZERO   = 3'd0;
  localparam logic [2:0] CLS_DENORM = 3'd1;
  localparam logic [2:0] CLS_NORMAL = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_QNAN   = 3'd4;
  localparam logic [2:0] CLS_SNAN   = 3'd5;

  // Result layout: {sign, exponent, significand, class}
  function automatic logic [DW-1:0] decode(input logic [W-1:0] w);
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [EXP_W-1:0] e_out;
    logic [MAN_W:0]   sig;
    logic [2:0]       cls;
    s     = w[W-1];
    e     = w[W-2:MAN_W];
    m     = w[MAN_W-1:0];
    e_out = e;
    sig   = {1'b1, m};
    cls   = CLS_NORMAL;
    if (e == '0) begin
      if (m == '0) begin
        e_out = '0;
        sig   = '0;
        cls   = CLS_ZERO;
      end else begin
`ifdef FLUSH_DENORM_EN
        e_out = '0;
        sig   = '0;
        cls   = CLS_ZERO;
`else
        e_out = EXP_W'(1);
        sig   = {1'b0, m};
        cls   = CLS_DENORM;
`endif
      end
    end else if (e == '1) begin
      if (m == '0)
        cls = CLS_INF;
      else if (m[MAN_W-1])
        cls = CLS_QNAN;
      else
        cls = CLS_SNAN;
    end
    return {s, e_out, sig, cls};
  endfunction

  function automatic logic is_special(input logic [2:0] cls);
    return !(cls == CLS_DENORM || cls == CLS_NORMAL);
  endfunction

  logic          s1_valid;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic          s2_valid;
  logic [DW-1:0] s2_a;
  logic [DW-1:0] s2_b;
  logic          s2_special;
  logic          s2_load;
  logic          accept;
  logic [DW-1:0] dec_a;
  logic [DW-1:0] dec_b;

  assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready = !s1_valid || s2_load;
  assign accept       = bus.in_valid && bus.in_ready;
  assign dec_a        = decode(s1_a);
  assign dec_b        = decode(s1_b);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.fp_a;
      s1_b     <= bus.fp_b;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Data holds when not reloading, so a stalled pair stays stable.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2_valid   <= 1'b0;
      s2_a       <= '0;
      s2_b       <= '0;
      s2_special <= 1'b0;
    end else if (s2_load) begin
      s2_valid   <= 1'b1;
      s2_a       <= dec_a;
      s2_b       <= dec_b;
      s2_special <= is_special(dec_a[2:0]) || is_special(dec_b[2:0]);
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid     = s2_valid;
  assign bus.a_sign        = s2_a[DW-1];
  assign bus.a_exponent    = s2_a[DW-2 -: EXP_W];
  assign bus.a_significand = s2_a[3 +: MAN_W+1];
  assign bus.a_class       = s2_a[2:0];
  assign bus.b_sign        = s2_b[DW-1];
  assign bus.b_exponent    = s2_b[DW-2 -: EXP_W];
  assign bus.b_significand = s2_b[3 +: MAN_W+1];
  assign bus.b_class       = s2_b[2:0];
  assign bus.special_any   = s2_special;
endmodule
